clk_div_prog: RTL
=================

# clk_div_prog

Runtime-programmable integer clock divider producing a 50 %-duty output for both odd and even ratios from one input clock. Divide ratio is reloaded glitch-free at period boundaries; enable/disable never truncates a period. Parametrised generalisation of the fixed odd-ratio divider, used wherever a clock ratio is chosen by software or a mode FSM.

## Interface
- `CNT_W`, 8: ratio and counter width; ratios 2..2^CNT_W-1 supported.
- `DEF_RATIO`, 5: active ratio after reset (clamped as below).
- `clk`  in  1  input clock; all logic on posedge except one negedge flop.
- `rstn`  in  1  asynchronous, active-low reset.
- `en`  in  1  run request, sampled on posedge.
- `div_ratio`  in  CNT_W  requested ratio N; 0 and 1 clamp to 2.
- `div_load`  in  1  one-cycle strobe capturing `div_ratio` into pending register.
- `clk_div`  out  1  divided clock, 50 % duty (odd N: high N/2 input periods incl. half cycle).
- `period_start`  out  1  high during input cycle with index 0 of each output period.
- `ratio_upd`  out  1  one-cycle pulse on the cycle a pending ratio becomes active.
- `active`  out  1  high while state is RUN or DRAIN.

## Operation
- Registers: `cnt` (index of current input cycle, 0..N-1), `p` (posedge output), `n` (negedge copy of `p`), `ratio_act`, `ratio_pend`, `pend_vld`, state.
- `nxt` = (cnt == ratio_act-1) ? 0 : cnt+1; `p <= (nxt < ratio_act>>1)`; `n <= p` on negedge; `clk_div = p | (ratio_act[0] & n)`.
- States: IDLE (cnt=0, p=0, output low), RUN, DRAIN.
- IDLE -> RUN: posedge with `en`=1; that cycle becomes index 0, `p`=1, `period_start`=1.
- RUN -> DRAIN: `en` sampled 0 while cnt != N-1; continue counting.
- RUN/DRAIN -> IDLE: posedge where cnt == N-1 and `en`=0; output stays low, cnt=0.
- DRAIN -> RUN: `en` re-sampled 1 before boundary; no period lost.
- RUN at boundary with `en`=1: wrap to index 0, next period begins.
- Ratio: `div_load` sets `ratio_pend`=clamp(`div_ratio`), `pend_vld`=1; later load overwrites earlier pending value.
- Apply pending ratio when wrapping to index 0 or on IDLE->RUN, and immediately while IDLE; `ratio_upd` pulses then.
- `div_load` on the same posedge as the wrap: new value applies to the period starting at that edge.
- Reset values: cnt=0, p=0, n=0, state IDLE, `ratio_act`=clamp(DEF_RATIO), `pend_vld`=0; `clk_div`, `period_start`, `ratio_upd`, `active` all 0.

## Timing
- Start latency: `clk_div` rises at the first posedge sampling `en`=1 (one clk-to-q).
- Even N: high exactly N/2 input periods, low N/2. Odd N: high (N-1)/2 periods plus half period via `n`, low remainder.
- No output pulse shorter than half an input period ever; ratio change and disable only take effect at index 0.
- `rstn` mid-period: `clk_div` low asynchronously; pending ratio discarded.
- `ratio_upd` and `period_start` coincident on ratio application from RUN.

## Structure
- Package `clk_div_pkg`: state enum (IDLE, RUN, DRAIN), `clamp_ratio` function, default widths.
- Sub-module `clk_div_negcap`: single negedge flop with async active-low reset generating `n`; keeps the negedge domain isolated for timing/CDC lint.
- Everything else in one module.

## Test plan
- N=5, en=1 from reset release -> `clk_div` high 2.5, low 2.5 input periods; `period_start` every 5 cycles.
- N=4 loaded while IDLE -> `ratio_upd` next cycle; run shows high 2, low 2 periods.
- Running N=6, load 3 at cnt=2 -> current period completes 6 cycles; next period 3 cycles (high 1.5); `ratio_upd` at that wrap.
- N=7, drop `en` at cnt=1 -> period completes all 7 cycles, `active` falls after wrap, output stays low.
- Load `div_ratio`=0 then 1 -> active ratio 2, output toggles every input cycle.
- Assert `rstn`=0 at cnt=3 of N=9 -> all outputs 0 immediately; after release, ratio is DEF_RATIO (5).

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable 50%-duty clock divider.
package clk_div_pkg;

    localparam int CNT_W_DEF     = 8;
    localparam int DEF_RATIO_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Ratios 0 and 1 cannot produce a 50% output, so they are promoted to 2.
    function automatic logic [31:0] clamp_ratio(input logic [31:0] r);
        return (r < 32'd2) ? 32'd2 : r;
    endfunction

endpackage

// File: rtl/clk_div_negcap.sv
// Falling-edge copy of the posedge output bit, used to add the half period for odd ratios.
module clk_div_negcap (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty for odd and even ratios.
// Ratio changes and disable requests only take effect on a period boundary.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DEF_RATIO = DEF_RATIO_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic             div_load,
    output logic             clk_div,
    output logic             period_start,
    output logic             ratio_upd,
    output logic             active
);

    localparam logic [CNT_W-1:0] RATIO_RST = CNT_W'(clamp_ratio(32'(DEF_RATIO)));

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             p_reg, p_next;
    logic             n_q;
    logic [CNT_W-1:0] ratio_act_reg, ratio_act_next;
    logic [CNT_W-1:0] ratio_pend_reg, ratio_pend_next;
    logic             pend_vld_reg, pend_vld_next;
    logic             ratio_upd_reg, ratio_upd_next;

    logic             at_last;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] eff_ratio;
    logic             eff_vld;
    logic             apply;

    assign at_last   = (cnt_reg == ratio_act_reg - CNT_W'(1));
    assign load_val  = CNT_W'(clamp_ratio(32'(div_ratio)));
    // A load on the same edge as a boundary bypasses the pending register.
    assign eff_vld   = div_load | pend_vld_reg;
    assign eff_ratio = div_load ? load_val : ratio_pend_reg;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (en) state_next = RUN;
            end
            RUN: begin
                if (!en) state_next = at_last ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (en)           state_next = RUN;
                else if (at_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        active       = (state_reg != IDLE);
        period_start = (state_reg != IDLE) && (cnt_reg == '0);
    end

    // Counter, ratio and output-bit datapath
    always_comb begin
        apply           = eff_vld && ((state_reg == IDLE) || (at_last && state_next != IDLE));
        ratio_act_next  = apply ? eff_ratio : ratio_act_reg;
        ratio_pend_next = div_load ? load_val : ratio_pend_reg;
        pend_vld_next   = apply ? 1'b0 : eff_vld;
        ratio_upd_next  = apply;

        if (state_next == IDLE || state_reg == IDLE || at_last) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
        p_next = (state_next != IDLE) && (cnt_next < (ratio_act_next >> 1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg        <= '0;
            p_reg          <= 1'b0;
            ratio_act_reg  <= RATIO_RST;
            ratio_pend_reg <= RATIO_RST;
            pend_vld_reg   <= 1'b0;
            ratio_upd_reg  <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            p_reg          <= p_next;
            ratio_act_reg  <= ratio_act_next;
            ratio_pend_reg <= ratio_pend_next;
            pend_vld_reg   <= pend_vld_next;
            ratio_upd_reg  <= ratio_upd_next;
        end
    end

    clk_div_negcap u_negcap (
        .clk  (clk),
        .rstn (rstn),
        .d    (p_reg),
        .q    (n_q)
    );

    // The negedge copy extends the high phase by half a cycle only for odd ratios.
    assign clk_div   = p_reg | (ratio_act_reg[0] & n_q);
    assign ratio_upd = ratio_upd_reg;

endmodule
